taxi_stats_accum: RTL and testbench
===================================

# taxi_stats_accum

Statistics accumulator that terminates the statistics increment stream. Each beat carries a counter ID and an increment. The block adds the increment into a per-counter RAM word and serves single-word reads of the accumulated values. It sits in the `stat_clk` domain downstream of the statistics FIFOs and arbiter, and presents its counters to a register or host interface.

## Interface
Parameters:
- `STAT_COUNT`, 64: number of counters; `IDX_W = $clog2(STAT_COUNT)`.
- `STAT_INC_W`, 16: increment width, taken from `tdata[STAT_INC_W-1:0]`.
- `STAT_W`, 48: accumulated counter width; must be ≥ `STAT_INC_W`.
- `ID_BASE`, 0: `tid` value mapped to counter 0.

Ports:
- `clk`  in  1: clock. One clock only.
- `rst`  in  1: reset, asynchronous, active-high.
- `s_axis_stat`  `taxi_axis_if.snk`: increment stream; `tid` = counter ID, `tdata` = increment; `tlast`/`tuser`/`tkeep` ignored.
- `rd_req_valid`  in  1: read request valid.
- `rd_req_ready`  out  1: read request accepted.
- `rd_req_addr`  in  IDX_W: counter index to read.
- `rd_resp_valid`  out  1: read data valid.
- `rd_resp_ready`  in  1: read data accepted.
- `rd_resp_data`  out  STAT_W: counter value.
- `init_done`  out  1: RAM clear complete.

## Operation
- State machine has two states, INIT and RUN. Reset enters INIT.
- INIT:
  - Index counter sweeps 0..STAT_COUNT-1, writing 0 to one word per cycle.
  - `s_axis_stat.tready`=0 and `rd_req_ready`=0 throughout.
  - After writing word STAT_COUNT-1, go to RUN and set `init_done`=1.
- RUN, slot arbitration: each cycle issues at most one operation into a 2-stage pipeline.
  - A read request wins over a stream beat.
  - `tready` = RUN && !(`rd_req_valid` && `rd_req_ready`).
- Update path:
  - Index = `tid` − `ID_BASE`.
  - If `tid` < `ID_BASE` or index ≥ STAT_COUNT, the beat is consumed and dropped, with no RAM effect.
  - Stage 1: RAM read at index, increment registered.
  - Stage 2: sum = old + zero-extended increment, modulo 2^STAT_W; written back.
- Forwarding: if the stage-2 write index equals the stage-1 index, stage 1 uses the stage-2 sum instead of RAM data. Back-to-back updates to the same counter are therefore lossless at full rate.
- Read path:
  - Uses the same pipeline and forwarding, so a read returns all updates accepted before it.
  - Only one read is outstanding: `rd_req_ready`=0 from acceptance until the response handshake.
- Response: `rd_resp_data` holds stable while `rd_resp_valid`=1 && `rd_resp_ready`=0.
- `rd_req_addr` ≥ STAT_COUNT returns 0.

## Timing
- Reset values:
  - `s_axis_stat.tready`=0, `rd_req_ready`=0, `rd_resp_valid`=0, `rd_resp_data`=0, `init_done`=0.
  - Pipeline valids cleared.
- INIT lasts exactly STAT_COUNT cycles after reset deassertion. `init_done` rises on the following edge.
- Update latency: the beat is accepted at cycle N; the RAM write happens at the N+1 edge; a read accepted at N+1 or later observes it.
- Read latency: request accepted at cycle N gives `rd_resp_valid`=1 at cycle N+2.
- Throughput: one update per cycle when no read is pending.
- Reset mid-operation:
  - In-flight updates and reads are discarded.
  - The FSM returns to INIT and all counters are cleared again.

## Configuration
- `TAXI_STATS_ACCUM_SAT_EN` defined: the stage-2 sum saturates at 2^STAT_W−1, detected by carry-out; a saturated counter stays at all-ones.
- Not defined: the sum wraps modulo 2^STAT_W.

## Structure
- Package `taxi_stats_pkg`:
  - FSM state enum (`STATE_INIT`, `STATE_RUN`).
  - Operation-type enum for pipeline tagging (`OP_UPD`, `OP_RD`).
- Sub-module `taxi_stats_accum_ram`:
  - Simple dual-port RAM, STAT_COUNT × STAT_W.
  - Registered read with 1-cycle latency, synchronous write.
  - No reset on the array.

## Test plan
- Reset, then wait STAT_COUNT cycles → `init_done`=1 at cycle STAT_COUNT+1; reading counters 0, 31 and 63 returns 0.
- Beat `tid`=5, `tdata`=100, then read addr 5 → `rd_resp_data`=100 two cycles after request acceptance.
- Eight consecutive beats `tid`=3, `tdata`=1..8 at full rate, then read 3 → 36 (forwarding path exercised).
- `rd_req_valid` held together with continuous stream traffic to `tid`=7 (`tdata`=1) → `tready` drops only in the read-accept cycle; the final read of 7 equals the total beats accepted.
- `ID_BASE`=16: beats with `tid`=15 and `tid`=80 → consumed with `tready`=1; no counter changes. A beat with `tid`=16, `tdata`=9 → counter 0 = 9.
- STAT_W=16, STAT_INC_W=16: beats 0xFFF0 then 0x0020 to counter 2:
  - With `TAXI_STATS_ACCUM_SAT_EN` → read = 0xFFFF.
  - Without it → read = 0x0010.

Source files
------------

// File: rtl/taxi_stats_pkg.sv
// Shared types for the statistics accumulator: FSM states and pipeline op tags.
package taxi_stats_pkg;

  typedef enum logic {
    STATE_INIT,
    STATE_RUN
  } state_t;

  typedef enum logic {
    OP_UPD,
    OP_RD
  } op_t;

endpackage

// File: rtl/taxi_axis_if.sv
// Minimal AXI-Stream interface carrying the fields used by the statistics path.
interface taxi_axis_if #(
  parameter int DATA_W = 16,
  parameter int KEEP_W = (DATA_W + 7) / 8,
  parameter int ID_W   = 8,
  parameter int USER_W = 1
) ();

  logic [DATA_W-1:0] tdata;
  logic [KEEP_W-1:0] tkeep;
  logic              tvalid;
  logic              tready;
  logic              tlast;
  logic [ID_W-1:0]   tid;
  logic [USER_W-1:0] tuser;

  modport src (output tdata, tkeep, tvalid, tlast, tid, tuser, input tready);
  modport snk (input tdata, tkeep, tvalid, tlast, tid, tuser, output tready);

endinterface

// File: rtl/taxi_stats_accum_ram.sv
// Simple dual-port counter RAM: synchronous write, registered 1-cycle read, no array reset.
module taxi_stats_accum_ram #(
  parameter int STAT_COUNT = 64,
  parameter int STAT_W     = 48,
  parameter int IDX_W      = $clog2(STAT_COUNT)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [STAT_W-1:0] wdata,
  input  logic [IDX_W-1:0]  raddr,
  output logic [STAT_W-1:0] rdata
);

  logic [STAT_W-1:0] mem [STAT_COUNT];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/taxi_stats_accum.sv
// Per-counter statistics accumulator with read port and INIT clear sweep.
// Optional macro TAXI_STATS_ACCUM_SAT_EN makes counters saturate instead of wrapping.
module taxi_stats_accum
  import taxi_stats_pkg::*;
#(
  parameter int STAT_COUNT = 64,
  parameter int STAT_INC_W = 16,
  parameter int STAT_W     = 48,
  parameter int ID_BASE    = 0,
  localparam int IDX_W     = $clog2(STAT_COUNT)
) (
  input  logic              clk,
  input  logic              rst,
  taxi_axis_if.snk          s_axis_stat,
  input  logic              rd_req_valid,
  output logic              rd_req_ready,
  input  logic [IDX_W-1:0]  rd_req_addr,
  output logic              rd_resp_valid,
  input  logic              rd_resp_ready,
  output logic [STAT_W-1:0] rd_resp_data,
  output logic              init_done
);

  function automatic logic [STAT_W-1:0] acc_add(input logic [STAT_W-1:0] a,
                                                input logic [STAT_INC_W-1:0] inc);
`ifdef TAXI_STATS_ACCUM_SAT_EN
    logic [STAT_W:0] full;
    full = {1'b0, a} + {1'b0, STAT_W'(inc)};
    return full[STAT_W] ? '1 : full[STAT_W-1:0];
`else
    return a + STAT_W'(inc);
`endif
  endfunction

  state_t state, state_next;
  logic [IDX_W-1:0] init_idx;
  logic rd_busy, stat_ready, rd_acc, upd_acc, upd_hit;
  logic [31:0] tid_ext;
  logic [32:0] upd_off;
  logic [IDX_W-1:0] iss_idx;
  logic [STAT_INC_W-1:0] inc;
  logic ram_we;
  logic [IDX_W-1:0] ram_waddr;
  logic [STAT_W-1:0] ram_wdata, ram_q;

  logic vld_p0, oob_p0;
  op_t op_p0;
  logic [IDX_W-1:0] idx_p0;
  logic [STAT_INC_W-1:0] inc_p0;
  logic [STAT_W-1:0] old_p0, sum_p0;

  logic vld_p1;
  logic [IDX_W-1:0] idx_p1;
  logic [STAT_W-1:0] sum_p1;

  logic unused_sig;
  assign unused_sig = ^{s_axis_stat.tdata, s_axis_stat.tkeep, s_axis_stat.tlast, s_axis_stat.tuser};

  assign s_axis_stat.tready = stat_ready;
  assign init_done = (state == STATE_RUN);

  assign tid_ext = 32'(s_axis_stat.tid);
  assign upd_off = {1'b0, tid_ext} - 33'(ID_BASE);
  assign upd_hit = !upd_off[32] && (upd_off[31:0] < 32'(STAT_COUNT));
  assign inc     = STAT_INC_W'(s_axis_stat.tdata);
  assign rd_acc  = rd_req_valid && rd_req_ready;
  assign upd_acc = s_axis_stat.tvalid && stat_ready;
  assign iss_idx = rd_acc ? rd_req_addr : upd_off[IDX_W-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= STATE_INIT;
    else     state <= state_next;
  end

  always_comb begin
    state_next   = state;
    rd_req_ready = 1'b0;
    stat_ready   = 1'b0;
    ram_we       = 1'b0;
    ram_waddr    = idx_p0;
    ram_wdata    = sum_p0;
    unique case (state)
      STATE_INIT: begin
        ram_we    = 1'b1;
        ram_waddr = init_idx;
        ram_wdata = '0;
        if (init_idx == IDX_W'(STAT_COUNT - 1)) state_next = STATE_RUN;
      end
      STATE_RUN: begin
        // A read request takes the issue slot ahead of a stream beat.
        rd_req_ready = !rd_busy;
        stat_ready   = !(rd_req_valid && !rd_busy);
        ram_we       = vld_p0 && (op_p0 == OP_UPD);
      end
    endcase
  end

  taxi_stats_accum_ram #(
    .STAT_COUNT(STAT_COUNT),
    .STAT_W    (STAT_W),
    .IDX_W     (IDX_W)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .waddr(ram_waddr),
    .wdata(ram_wdata),
    .raddr(iss_idx),
    .rdata(ram_q)
  );

  // Stage p0: RAM word arrives; forward the write of the previous cycle, which the RAM read missed.
  assign old_p0 = (vld_p1 && (idx_p1 == idx_p0)) ? sum_p1 : ram_q;
  assign sum_p0 = acc_add(old_p0, inc_p0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      init_idx      <= '0;
      rd_busy       <= 1'b0;
      vld_p0        <= 1'b0;
      vld_p1        <= 1'b0;
      rd_resp_valid <= 1'b0;
      rd_resp_data  <= '0;
    end else begin
      if (state == STATE_INIT) init_idx <= init_idx + 1'b1;
      vld_p0 <= rd_acc || (upd_acc && upd_hit);
      vld_p1 <= vld_p0 && (op_p0 == OP_UPD);
      if (rd_acc) rd_busy <= 1'b1;
      else if (rd_resp_valid && rd_resp_ready) rd_busy <= 1'b0;
      if (vld_p0 && (op_p0 == OP_RD)) begin
        rd_resp_valid <= 1'b1;
        rd_resp_data  <= oob_p0 ? '0 : old_p0;
      end else if (rd_resp_valid && rd_resp_ready) begin
        rd_resp_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    op_p0  <= rd_acc ? OP_RD : OP_UPD;
    idx_p0 <= iss_idx;
    inc_p0 <= inc;
    oob_p0 <= 32'(rd_req_addr) >= 32'(STAT_COUNT);
    idx_p1 <= idx_p0;
    sum_p1 <= sum_p0;
  end

endmodule

// File: tb/tb_taxi_stats_accum.sv
// Directed bench for taxi_stats_accum: default, ID_BASE=16 and 16-bit counter instances.
module tb_taxi_stats_accum;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  logic        tv  [3];
  logic [7:0]  tidv[3];
  logic [15:0] tdv [3];
  logic        rqv [3];
  logic [5:0]  rqa [3];
  logic        rsr [3];
  logic        tr  [3];
  logic        rqr [3];
  logic        rsv [3];
  logic        idn [3];
  logic [47:0] rsd [3];
  logic [47:0] rsd0, rsd1;
  logic [15:0] rsd_w16;
  logic [47:0] exp_q[$];

  taxi_axis_if #(.DATA_W(16), .ID_W(8)) ax0 ();
  taxi_axis_if #(.DATA_W(16), .ID_W(8)) ax1 ();
  taxi_axis_if #(.DATA_W(16), .ID_W(8)) ax2 ();

  assign ax0.tvalid = tv[0]; assign ax0.tid = tidv[0]; assign ax0.tdata = tdv[0];
  assign ax1.tvalid = tv[1]; assign ax1.tid = tidv[1]; assign ax1.tdata = tdv[1];
  assign ax2.tvalid = tv[2]; assign ax2.tid = tidv[2]; assign ax2.tdata = tdv[2];
  assign ax0.tkeep = '1; assign ax0.tlast = 1'b1; assign ax0.tuser = '0;
  assign ax1.tkeep = '1; assign ax1.tlast = 1'b1; assign ax1.tuser = '0;
  assign ax2.tkeep = '1; assign ax2.tlast = 1'b1; assign ax2.tuser = '0;
  assign tr[0] = ax0.tready; assign tr[1] = ax1.tready; assign tr[2] = ax2.tready;
  assign rsd[0] = rsd0; assign rsd[1] = rsd1; assign rsd[2] = {32'h0, rsd_w16};

  taxi_stats_accum dut0 (
    .clk(clk), .rst(rst), .s_axis_stat(ax0),
    .rd_req_valid(rqv[0]), .rd_req_ready(rqr[0]), .rd_req_addr(rqa[0]),
    .rd_resp_valid(rsv[0]), .rd_resp_ready(rsr[0]), .rd_resp_data(rsd0),
    .init_done(idn[0])
  );

  taxi_stats_accum #(.ID_BASE(16)) dut1 (
    .clk(clk), .rst(rst), .s_axis_stat(ax1),
    .rd_req_valid(rqv[1]), .rd_req_ready(rqr[1]), .rd_req_addr(rqa[1]),
    .rd_resp_valid(rsv[1]), .rd_resp_ready(rsr[1]), .rd_resp_data(rsd1),
    .init_done(idn[1])
  );

  taxi_stats_accum #(.STAT_W(16), .STAT_INC_W(16)) dut2 (
    .clk(clk), .rst(rst), .s_axis_stat(ax2),
    .rd_req_valid(rqv[2]), .rd_req_ready(rqr[2]), .rd_req_addr(rqa[2]),
    .rd_resp_valid(rsv[2]), .rd_resp_ready(rsr[2]), .rd_resp_data(rsd_w16),
    .init_done(idn[2])
  );

  task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Enter and leave at a falling edge; the beat is accepted on the rising edge in between.
  task automatic beat(input int i, input logic [7:0] id, input logic [15:0] d);
    int n;
    n = 0;
    tv[i] = 1'b1; tidv[i] = id; tdv[i] = d;
    while (!tr[i] && n < 50) begin @(negedge clk); n++; end
    if (n == 50) chk("beat_timeout", 48'd0, 48'd1);
    @(negedge clk);
    tv[i] = 1'b0;
  endtask

  task automatic rd(input int i, input logic [5:0] a, input logic [47:0] e,
                    input int hold, input string tag);
    int n;
    logic [47:0] d0;
    n = 0;
    rqv[i] = 1'b1; rqa[i] = a;
    while (!rqr[i] && n < 50) begin @(negedge clk); n++; end
    if (n == 50) chk({tag, "_req_timeout"}, 48'd0, 48'd1);
    exp_q.push_back(e);
    @(negedge clk);
    rqv[i] = 1'b0;
    chk({tag, "_lat1"}, 48'(rsv[i]), 48'd0);
    @(negedge clk);
    chk({tag, "_lat2"}, 48'(rsv[i]), 48'd1);
    n = 0;
    while (!rsv[i] && n < 20) begin @(negedge clk); n++; end
    d0 = rsd[i];
    chk(tag, d0, exp_q.pop_front());
    repeat (hold) begin
      @(negedge clk);
      chk({tag, "_hold"}, rsd[i], d0);
    end
    rsr[i] = 1'b1;
    @(negedge clk);
    rsr[i] = 1'b0;
    chk({tag, "_drop"}, 48'(rsv[i]), 48'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_tready", 48'(tr[0]), 48'd0);
    chk("rst_req_ready", 48'(rqr[0]), 48'd0);
    chk("rst_resp_valid", 48'(rsv[0]), 48'd0);
    chk("rst_resp_data", rsd[0], 48'd0);
    chk("rst_init_done", 48'(idn[0]), 48'd0);
    rst = 1'b0;
    repeat (63) @(negedge clk);
    chk("init_done_early", 48'(idn[0]), 48'd0);
    chk("init_tready", 48'(tr[0]), 48'd0);
    chk("init_req_ready", 48'(rqr[0]), 48'd0);
    @(negedge clk);
    chk("init_done", 48'(idn[0]), 48'd1);
    chk("init_done_b", 48'(idn[1]), 48'd1);
    chk("init_done_w16", 48'(idn[2]), 48'd1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int beats;
    logic acc;
    for (int k = 0; k < 3; k++) begin
      tv[k] = 1'b0; tidv[k] = '0; tdv[k] = '0;
      rqv[k] = 1'b0; rqa[k] = '0; rsr[k] = 1'b0;
    end
    @(negedge clk);
    do_reset();

    rd(0, 6'd0, 48'd0, 0, "clr0");
    rd(0, 6'd31, 48'd0, 2, "clr31");
    rd(0, 6'd63, 48'd0, 0, "clr63");

    beat(0, 8'd5, 16'd100);
    rd(0, 6'd5, 48'd100, 1, "single5");

    for (int k = 1; k <= 8; k++) beat(0, 8'd3, 16'(k));
    rd(0, 6'd3, 48'd36, 0, "fwd3");

    // Continuous stream to counter 7 while one read is issued mid-stream.
    beats = 0;
    tv[0] = 1'b1; tidv[0] = 8'd7; tdv[0] = 16'd1; rsr[0] = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (c == 5) begin rqv[0] = 1'b1; rqa[0] = 6'd7; end
      #1;
      acc = rqv[0] && rqr[0];
      chk("stream_tready", 48'(tr[0]), 48'(!acc));
      if (acc) exp_q.push_back(48'(beats));
      if (rsv[0]) chk("stream_rd", rsd[0], exp_q.pop_front());
      beats += acc ? 0 : 1;
      @(negedge clk);
      if (acc) rqv[0] = 1'b0;
    end
    tv[0] = 1'b0; rsr[0] = 1'b0;
    chk("stream_rd_done", 48'(exp_q.size()), 48'd0);
    exp_q.delete();
    rd(0, 6'd7, 48'(beats), 0, "stream_total");

    chk("base_tready15", 48'(tr[1]), 48'd1);
    beat(1, 8'd15, 16'd5);
    chk("base_tready80", 48'(tr[1]), 48'd1);
    beat(1, 8'd80, 16'd7);
    rd(1, 6'd0, 48'd0, 0, "base_c0_clean");
    rd(1, 6'd63, 48'd0, 0, "base_c63_clean");
    beat(1, 8'd16, 16'd9);
    rd(1, 6'd0, 48'd9, 0, "base_c0");

    beat(2, 8'd2, 16'hFFF0);
    beat(2, 8'd2, 16'h0020);
`ifdef TAXI_STATS_ACCUM_SAT_EN
    rd(2, 6'd2, 48'hFFFF, 0, "w16_sat");
`else
    rd(2, 6'd2, 48'h0010, 0, "w16_wrap");
`endif

    // Reset with an update in flight: everything is cleared again.
    tv[0] = 1'b1; tidv[0] = 8'd9; tdv[0] = 16'd5;
    @(posedge clk);
    #1;
    tv[0] = 1'b0;
    do_reset();
    rd(0, 6'd9, 48'd0, 0, "rst_mid9");
    rd(0, 6'd5, 48'd0, 0, "rst_mid5");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
